// File: rtl/cache_req_issuer.sv
// Per-processor request front-end for the shared cache: a small request FIFO,
// a one-at-a-time issue FSM on the 22-bit request line, and response matching.
module cache_req_issuer #(
  parameter logic PID     = 1'b0,
  parameter int   DEPTH   = 4,
  parameter int   TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_valid,
  input  logic                     push_store,
  input  logic [10:0]              push_tag,
  input  logic                     push_offset,
  input  logic [7:0]               push_data,
  output logic                     push_ready,
  input  logic                     cache_busy,
  output wire  [21:0]              req_out,
  input  logic [21:0]              resp_in,
  output logic                     resp_valid,
  output logic [7:0]               resp_data,
  output logic                     resp_store,
  output logic                     timeout_err,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE   = (AW+1)'(1);
  localparam logic [CW-1:0] WLAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  // Entry layout {store, tag[10:0], offset, data[7:0]} lines up with req/resp bits [20:0].
  logic [20:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [CW-1:0] wait_q;
  state_t        state_q;
  logic          resp_valid_q, resp_store_q, timeout_err_q;
  logic [7:0]    resp_data_q;

  logic [20:0] head;
  logic        do_push, do_pop, match;

  assign head       = mem[rd_ptr_q];
  assign push_ready = (count_q != FULL);
  assign do_push    = push_valid && push_ready;
  // x/z anywhere in the header bits must fail the compare, hence case-equality.
  assign match      = (resp_in[21:8] === {PID, head[20:8]});
  assign do_pop     = (state_q == WAIT) && match;

  assign req_out     = (state_q == ISSUE) ? {PID, head} : {22{1'bz}};
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign resp_store  = resp_store_q;
  assign timeout_err = timeout_err_q;
  assign fifo_count  = count_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)
      count_d = count_q + ONE;
    else if (!do_push && do_pop)
      count_d = count_q - ONE;
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr_q] <= {push_store, push_tag, push_offset, push_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      wait_q        <= '0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      resp_store_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      count_q      <= count_d;
      if (do_push)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;

      case (state_q)
        IDLE: begin
          if (count_q != '0 && !cache_busy)
            state_q <= ISSUE;
        end
        ISSUE: begin
          state_q <= WAIT;
          wait_q  <= '0;
        end
        WAIT: begin
          if (match) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= resp_in[7:0];
            resp_store_q <= head[20];
            state_q      <= (count_q > ONE && !cache_busy) ? ISSUE : IDLE;
          end else if (wait_q == WLAST) begin
            // Head stays queued; IDLE will reissue it.
            timeout_err_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_req_issuer.sv
module tb_cache_req_issuer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        p0_pv = 1'b0, p0_st = 1'b0, p0_off = 1'b0;
  logic [10:0] p0_tag = '0;
  logic [7:0]  p0_d = '0;
  logic        p1_pv = 1'b0, p1_st = 1'b0, p1_off = 1'b0;
  logic [10:0] p1_tag = '0;
  logic [7:0]  p1_d = '0;

  wire         p0_rdy, p1_rdy, p0_rv, p1_rv, p0_rs, p1_rs, p0_to, p1_to;
  wire  [7:0]  p0_rd, p1_rd;
  wire  [2:0]  p0_cnt, p1_cnt;
  wire  [21:0] p0_req, p1_req;

  logic        busy_q = 1'b0;
  logic        force_busy = 1'b0;
  logic        mute = 1'b0;
  logic [21:0] pend_q = '0;
  logic [21:0] dout = {22{1'bz}};
  logic        st_v;
  logic [11:0] st_a;
  logic [7:0]  st_d;
  logic        cache_busy;
  logic        sel_v;
  logic [21:0] sel_req;

  int n_pass = 0, n_fail = 0, n_total = 0;
  int rv_seen;
  bit got;
  logic [7:0] t4_exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  assign cache_busy = busy_q | force_busy;

  cache_req_issuer #(.PID(1'b0), .DEPTH(4), .TIMEOUT(8)) u_p0 (
    .clk(clk), .rst_n(rst_n), .push_valid(p0_pv), .push_store(p0_st), .push_tag(p0_tag),
    .push_offset(p0_off), .push_data(p0_d), .push_ready(p0_rdy), .cache_busy(cache_busy),
    .req_out(p0_req), .resp_in(dout), .resp_valid(p0_rv), .resp_data(p0_rd),
    .resp_store(p0_rs), .timeout_err(p0_to), .fifo_count(p0_cnt));

  cache_req_issuer #(.PID(1'b1), .DEPTH(4), .TIMEOUT(8)) u_p1 (
    .clk(clk), .rst_n(rst_n), .push_valid(p1_pv), .push_store(p1_st), .push_tag(p1_tag),
    .push_offset(p1_off), .push_data(p1_d), .push_ready(p1_rdy), .cache_busy(cache_busy),
    .req_out(p1_req), .resp_in(dout), .resp_valid(p1_rv), .resp_data(p1_rd),
    .resp_store(p1_rs), .timeout_err(p1_to), .fifo_count(p1_cnt));

    function automatic logic drv(input logic [21:0] r);
        return !$isunknown(r) && (r != 22'd0);
    endfunction

    function automatic logic idle_line(input logic [21:0] r);
        return (r === {22{1'bz}}) || (r === 22'd0);
    endfunction

    function automatic logic [7:0] init_val(input logic [11:0] a);
        case (a)
            {11'b01010000000, 1'b0}: return 8'h64;
            {11'h0C0, 1'b0}:         return 8'h99;
            {11'h003, 1'b1}:         return 8'h3C;
            {11'h101, 1'b0}:         return 8'h11;
            {11'h102, 1'b0}:         return 8'h22;
            {11'h103, 1'b0}:         return 8'h33;
            {11'h104, 1'b0}:         return 8'h44;
            {11'h2AA, 1'b1}:         return 8'h5A;
            {11'h155, 1'b0}:         return 8'h77;
            default:                 return 8'h00;
        endcase
    endfunction

    always_comb begin
        sel_v   = 1'b0;
        sel_req = '0;
        if (busy_q) begin
            sel_v = 1'b1; sel_req = pend_q;
        end else if (drv(p0_req)) begin
            sel_v = 1'b1; sel_req = p0_req;
        end else if (drv(p1_req)) begin
            sel_v = 1'b1; sel_req = p1_req;
        end
    end

    always @(posedge clk) begin
        if (!rst_n && !mute) begin
            st_v <= 1'b0;
        end
        if (mute) begin
            dout <= {22{1'bz}};
        end else if (sel_v) begin
            dout <= {sel_req[21:8], sel_req[20] ? sel_req[7:0] :
                     ((st_v === 1'b1 && st_a == sel_req[19:8]) ? st_d : init_val(sel_req[19:8]))};
            if (sel_req[20]) begin
                st_v <= 1'b1; st_a <= sel_req[19:8]; st_d <= sel_req[7:0];
            end
        end
        busy_q <= !busy_q && !mute && drv(p0_req) && drv(p1_req);
        if (!busy_q) pend_q <= p1_req;
    end

    task automatic check(input string tag, input bit ok);
        n_total++;
        if (ok) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s", tag);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push0(input logic st, input logic [10:0] tag, input logic off, input logic [7:0] d);
        p0_pv = 1'b1; p0_st = st; p0_tag = tag; p0_off = off; p0_d = d;
    endtask

    task automatic wait_p0(input int max, output bit found);
        found = 1'b0;
        for (int i = 0; i < max && !found; i++) begin
            step();
            if (p0_rv) found = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) step();
        check("rst resp_valid", p0_rv === 1'b0);
        check("rst resp_data", p0_rd === 8'h00);
        check("rst resp_store", p0_rs === 1'b0);
        check("rst timeout_err", p0_to === 1'b0);
        check("rst fifo_count", p0_cnt === 3'd0);
        check("rst push_ready", p0_rdy === 1'b1);
        check("rst req idle", idle_line(p0_req) === 1'b1);
        rst_n = 1'b1;
        step();

        push0(1'b0, 11'b01010000000, 1'b0, 8'h00);
        step(); p0_pv = 1'b0;
        check("t1 count after push", p0_cnt === 3'd1);
        step();
        check("t1 req word", p0_req === 22'b0_0_01010000000_0_00000000);
        step();
        check("t1 req released", idle_line(p0_req) === 1'b1);
        check("t1 no early valid", p0_rv === 1'b0);
        step();
        check("t1 resp_valid", p0_rv === 1'b1);
        check("t1 resp_data", p0_rd === 8'h64);
        check("t1 count drained", p0_cnt === 3'd0);
        step();
        check("t1 valid pulse ends", p0_rv === 1'b0);
        check("t1 data held", p0_rd === 8'h64);

        push0(1'b1, 11'b01010001000, 1'b1, 8'hA5);
        step();
        push0(1'b0, 11'b01010001000, 1'b1, 8'h00);
        step(); p0_pv = 1'b0;
        check("t2 store issued", p0_req === {1'b0, 1'b1, 11'b01010001000, 1'b1, 8'hA5});
        step();
        step();
        check("t2 store valid", p0_rv === 1'b1);
        check("t2 store data", p0_rd === 8'hA5);
        check("t2 store type", p0_rs === 1'b1);
        check("t2 load queued", p0_cnt === 3'd1);
        check("t2 load issued", p0_req === {1'b0, 1'b0, 11'b01010001000, 1'b1, 8'h00});
        step();
        check("t2 gap cycle", p0_rv === 1'b0);
        step();
        check("t2 load valid", p0_rv === 1'b1);
        check("t2 load data", p0_rd === 8'hA5);
        check("t2 load type", p0_rs === 1'b0);

        push0(1'b0, 11'h0C0, 1'b0, 8'h00);
        p1_pv = 1'b1; p1_st = 1'b0; p1_tag = 11'h003; p1_off = 1'b1; p1_d = 8'h00;
        step(); p0_pv = 1'b0; p1_pv = 1'b0;
        step();
        check("t3 p1 issued", p1_req === {1'b1, 1'b0, 11'h003, 1'b1, 8'h00});
        step();
        check("t3 busy raised", cache_busy === 1'b1);
        check("t3 p0 idle in busy", idle_line(p0_req) === 1'b1);
        check("t3 p1 idle in busy", idle_line(p1_req) === 1'b1);
        step();
        check("t3 p0 valid +2", p0_rv === 1'b1);
        check("t3 p0 data", p0_rd === 8'h99);
        check("t3 p1 not yet", p1_rv === 1'b0);
        step();
        check("t3 p1 valid +3", p1_rv === 1'b1);
        check("t3 p1 data", p1_rd === 8'h3C);
        check("t3 p1 drained", p1_cnt === 3'd0);

        force_busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            push0(1'b0, 11'(11'h101 + k), 1'b0, 8'h00);
            step();
            if (k == 2) check("t4 ready before full", p0_rdy === 1'b1);
            if (k == 3) check("t4 ready falls", p0_rdy === 1'b0);
        end
        p0_pv = 1'b0;
        check("t4 count full", p0_cnt === 3'd4);
        check("t4 no issue while busy", idle_line(p0_req) === 1'b1);
        force_busy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_p0(8, got);
            check("t4 response seen", got === 1'b1);
            check("t4 response data", p0_rd === t4_exp[k]);
        end
        check("t4 drained", p0_cnt === 3'd0);
        wait_p0(6, got);
        check("t4 fifth dropped", got === 1'b0);

        mute = 1'b1;
        push0(1'b0, 11'h2AA, 1'b1, 8'h00);
        step(); p0_pv = 1'b0;
        step();
        check("t5 issued", p0_req === {1'b0, 1'b0, 11'h2AA, 1'b1, 8'h00});
        step();
        repeat (7) step();
        check("t5 no timeout yet", p0_to === 1'b0);
        step();
        check("t5 timeout set", p0_to === 1'b1);
        check("t5 head retained", p0_cnt === 3'd1);
        mute = 1'b0;
        step();
        check("t5 reissued", p0_req === {1'b0, 1'b0, 11'h2AA, 1'b1, 8'h00});
        step();
        step();
        check("t5 resp_valid", p0_rv === 1'b1);
        check("t5 resp_data", p0_rd === 8'h5A);
        check("t5 timeout sticky", p0_to === 1'b1);
        check("t5 drained", p0_cnt === 3'd0);

        push0(1'b0, 11'h155, 1'b0, 8'h00);
        step(); p0_pv = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("t6 resp_valid", p0_rv === 1'b0);
        check("t6 resp_data", p0_rd === 8'h00);
        check("t6 resp_store", p0_rs === 1'b0);
        check("t6 timeout cleared", p0_to === 1'b0);
        check("t6 count", p0_cnt === 3'd0);
        check("t6 push_ready", p0_rdy === 1'b1);
        check("t6 req idle", idle_line(p0_req) === 1'b1);
        #2 rst_n = 1'b1;
        rv_seen = 0;
        repeat (4) begin
            step();
            if (p0_rv) rv_seen++;
        end
        check("t6 late response ignored", rv_seen === 0);
        check("t6 still empty", p0_cnt === 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
